// File: rtl/one_unit_dot4_if.sv
// Handshake and data bundle for the one_unit_dot4 projection stage.
//   in_valid/in_ready    : upstream handshake carrying z1..z4 and w11..w44
//   out_valid/out_ready  : downstream handshake carrying y1..y4 and out_ovf
// All data words are signed Q13, DW bits wide.
// The slave modport is the dot-product block; the master modport is the environment around it.
interface one_unit_dot4_if #(
    parameter int DW = 26
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] z1, z2, z3, z4;
    logic signed [DW-1:0] w11, w12, w13, w14;
    logic signed [DW-1:0] w21, w22, w23, w24;
    logic signed [DW-1:0] w31, w32, w33, w34;
    logic signed [DW-1:0] w41, w42, w43, w44;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] y1, y2, y3, y4;
    logic                 out_ovf;

    modport slave (
        input  in_valid, z1, z2, z3, z4,
               w11, w12, w13, w14, w21, w22, w23, w24,
               w31, w32, w33, w34, w41, w42, w43, w44,
               out_ready,
        output in_ready, out_valid, y1, y2, y3, y4, out_ovf
    );

    modport master (
        output in_valid, z1, z2, z3, z4,
               w11, w12, w13, w14, w21, w22, w23, w24,
               w31, w32, w33, w34, w41, w42, w43, w44,
               out_ready,
        input  in_ready, out_valid, y1, y2, y3, y4, out_ovf
    );
endinterface

// File: rtl/one_unit_dot4.sv
// one_unit_dot4: projection y = W*z (4x4 weights times 4x1 whitened sample)
// for the FastICA one-unit update path, using one time-shared signed
// multiplier and accumulator.
// Ports:
//   clk_dot : clock, rising edge
//   rst_dot : asynchronous active-high reset
//   bus     : one_unit_dot4_if.slave (z/W input handshake, y/out_ovf output handshake)
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready=1
// MAC   | cnt[3:0] walks row/col through 16 products; cnt[4] marks the final hand-off cycle
// DONE  | y1..y4/out_ovf presented with out_valid=1 until out_ready
module one_unit_dot4 #(
    parameter int DW   = 26,
    parameter int FRAC = 13,
    parameter int AW   = 2*DW+2
) (
    input  logic            clk_dot,
    input  logic            rst_dot,
    one_unit_dot4_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    localparam int HW = AW-DW-FRAC+1;   // accumulator bits that must all match for y to fit

    state_t               state_q, state_d;
    logic [4:0]           cnt_q, cnt_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [DW-1:0] z_q [4];
    logic signed [DW-1:0] z_d [4];
    logic signed [DW-1:0] w_q [16];
    logic signed [DW-1:0] w_d [16];
    logic signed [DW-1:0] y_q [4];
    logic signed [DW-1:0] y_d [4];
    logic                 out_valid_q, out_valid_d;
    logic                 out_ovf_q, out_ovf_d;

    logic signed [DW-1:0]   z_in [4];
    logic signed [DW-1:0]   w_in [16];
    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   sum;
    logic [HW-1:0]          sum_hi;

    assign z_in[0] = bus.z1;  assign z_in[1] = bus.z2;  assign z_in[2] = bus.z3;  assign z_in[3] = bus.z4;
    assign w_in[0]  = bus.w11; assign w_in[1]  = bus.w12; assign w_in[2]  = bus.w13; assign w_in[3]  = bus.w14;
    assign w_in[4]  = bus.w21; assign w_in[5]  = bus.w22; assign w_in[6]  = bus.w23; assign w_in[7]  = bus.w24;
    assign w_in[8]  = bus.w31; assign w_in[9]  = bus.w32; assign w_in[10] = bus.w33; assign w_in[11] = bus.w34;
    assign w_in[12] = bus.w41; assign w_in[13] = bus.w42; assign w_in[14] = bus.w43; assign w_in[15] = bus.w44;

    // Both operands are signed, so the 2*DW product and its extension into sum stay signed.
    assign prod   = z_q[cnt_q[1:0]] * w_q[cnt_q[3:0]];
    assign sum    = acc_q + prod;
    assign sum_hi = sum[AW-1:DW+FRAC-1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        z_d         = z_q;
        w_d         = w_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    z_d       = z_in;
                    w_d       = w_in;
                    cnt_d     = '0;
                    acc_d     = '0;
                    out_ovf_d = 1'b0;
                    state_d   = MAC;
                end
            end
            MAC: begin
                if (cnt_q[4]) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    if (cnt_q[1:0] != 2'd3) begin
                        acc_d = sum;
                    end else begin
                        // Truncating slice: rounds toward -inf, wraps on overflow.
                        y_d[cnt_q[3:2]] = sum[DW+FRAC-1:FRAC];
                        out_ovf_d       = out_ovf_q | ~((&sum_hi) | ~(|sum_hi));
                        acc_d           = '0;
                    end
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_dot or posedge rst_dot) begin
        if (rst_dot) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_ovf_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                z_q[i] <= '0;
                y_q[i] <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_ovf_q   <= out_ovf_d;
            z_q         <= z_d;
            w_q         <= w_d;
            y_q         <= y_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) & ~rst_dot;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.y1        = y_q[0];
    assign bus.y2        = y_q[1];
    assign bus.y3        = y_q[2];
    assign bus.y4        = y_q[3];
endmodule

// File: tb/tb_one_unit_dot4.sv
module tb_one_unit_dot4;
    localparam int DW = 26;

    typedef logic signed [DW-1:0] vec4_t [4];
    typedef logic signed [DW-1:0] mat_t [16];
    typedef struct {
        vec4_t z;
        mat_t  w;
        vec4_t y;
        logic  ovf;
    } vec_rec_t;

    logic clk_dot = 1'b0;
    logic rst_dot = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    one_unit_dot4_if #(.DW(DW)) bus ();

    one_unit_dot4 #(.DW(DW)) dut (
        .clk_dot (clk_dot),
        .rst_dot (rst_dot),
        .bus     (bus.slave)
    );

    always #5 clk_dot = ~clk_dot;

    function automatic void chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    // Reference: exact integer dot products, floor-divided by 2^13, wrapped to DW bits.
    function automatic void model(input vec4_t z, input mat_t w, output vec4_t y, output logic ovf);
        longint sum, q;
        ovf = 1'b0;
        for (int r = 0; r < 4; r++) begin
            sum = 0;
            for (int c = 0; c < 4; c++) sum += longint'(w[r*4+c]) * longint'(z[c]);
            q = sum >>> 13;
            y[r] = q[DW-1:0];
            if (q < -(64'sd1 <<< (DW-1)) || q >= (64'sd1 <<< (DW-1))) ovf = 1'b1;
        end
    endfunction

    task automatic drive(input vec4_t z, input mat_t w);
        bus.z1 = z[0]; bus.z2 = z[1]; bus.z3 = z[2]; bus.z4 = z[3];
        bus.w11 = w[0];  bus.w12 = w[1];  bus.w13 = w[2];  bus.w14 = w[3];
        bus.w21 = w[4];  bus.w22 = w[5];  bus.w23 = w[6];  bus.w24 = w[7];
        bus.w31 = w[8];  bus.w32 = w[9];  bus.w33 = w[10]; bus.w34 = w[11];
        bus.w41 = w[12]; bus.w42 = w[13]; bus.w43 = w[14]; bus.w44 = w[15];
    endtask

    task automatic drive_garbage();
        vec4_t z;
        mat_t  w;
        for (int i = 0; i < 4; i++)  z[i] = DW'($urandom);
        for (int i = 0; i < 16; i++) w[i] = DW'($urandom);
        drive(z, w);
    endtask

    function automatic vec4_t get_y();
        vec4_t y;
        y[0] = bus.y1; y[1] = bus.y2; y[2] = bus.y3; y[3] = bus.y4;
        return y;
    endfunction

    // Present one operation, measure latency, check results, hold in DONE for 'hold' cycles, consume.
    task automatic run_op(input string tag, input vec4_t z, input mat_t w,
                          input vec4_t ey, input logic eovf, input int hold);
        int    edges;
        vec4_t yv;
        @(negedge clk_dot);
        drive(z, w);
        bus.in_valid = 1'b1;
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk_dot); #1;
        bus.in_valid = 1'b0;
        drive_garbage();
        chk({tag, ".valid_after_accept"}, 64'(bus.out_valid), 64'd0);
        edges = 0;
        while (!bus.out_valid && edges < 40) begin
            @(posedge clk_dot); #1;
            edges++;
        end
        chk({tag, ".latency"}, 64'(edges), 64'd17);
        yv = get_y();
        for (int r = 0; r < 4; r++) chk($sformatf("%s.y%0d", tag, r+1), 64'(yv[r]), 64'(ey[r]));
        chk({tag, ".ovf"}, 64'(bus.out_ovf), 64'(eovf));
        chk({tag, ".in_ready_done"}, 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_dot); #1;
            chk($sformatf("%s.hold%0d.valid", tag, i), 64'(bus.out_valid), 64'd1);
            chk($sformatf("%s.hold%0d.in_ready", tag, i), 64'(bus.in_ready), 64'd0);
            chk($sformatf("%s.hold%0d.ovf", tag, i), 64'(bus.out_ovf), 64'(eovf));
            yv = get_y();
            for (int r = 0; r < 4; r++) chk($sformatf("%s.hold%0d.y%0d", tag, i, r+1), 64'(yv[r]), 64'(ey[r]));
        end
        @(negedge clk_dot);
        bus.out_ready = 1'b1;
        @(posedge clk_dot); #1;
        bus.out_ready = 1'b0;
        chk({tag, ".valid_cleared"}, 64'(bus.out_valid), 64'd0);
        chk({tag, ".in_ready_idle"}, 64'(bus.in_ready), 64'd1);
    endtask

    vec_rec_t tbl [6];

    initial begin
        vec4_t z, ey, yv;
        mat_t  w;
        logic  eovf;
        int    mode;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive_garbage();

        // Identity
        tbl[0].z = '{26'sd8192, 26'sd16384, -26'sd8192, 26'sd4096};
        for (int i = 0; i < 16; i++) tbl[0].w[i] = (i % 5 == 0) ? 26'sd8192 : 26'sd0;
        tbl[0].y = '{26'sd8192, 26'sd16384, -26'sd8192, 26'sd4096};
        tbl[0].ovf = 1'b0;
        // All 0.5 weights
        tbl[1].z = '{26'sd8192, 26'sd8192, 26'sd8192, 26'sd8192};
        for (int i = 0; i < 16; i++) tbl[1].w[i] = 26'sd4096;
        tbl[1].y = '{26'sd16384, 26'sd16384, 26'sd16384, 26'sd16384};
        tbl[1].ovf = 1'b0;
        // Row 2 negated
        tbl[2] = tbl[1];
        for (int c = 0; c < 4; c++) tbl[2].w[4+c] = -26'sd4096;
        tbl[2].y = '{26'sd16384, -26'sd16384, 26'sd16384, 26'sd16384};
        // Negative truncation toward -inf
        tbl[3].z = '{26'sd1, 26'sd0, 26'sd0, 26'sd0};
        for (int i = 0; i < 16; i++) tbl[3].w[i] = 26'sd0;
        tbl[3].w[0] = -26'sd1;
        tbl[3].y = '{-26'sd1, 26'sd0, 26'sd0, 26'sd0};
        tbl[3].ovf = 1'b0;
        // Overflow: 4*2^48 wraps to zero in the slice
        tbl[4].z = '{26'sd16777216, 26'sd16777216, 26'sd16777216, 26'sd16777216};
        for (int i = 0; i < 16; i++) tbl[4].w[i] = 26'sd16777216;
        tbl[4].y = '{26'sd0, 26'sd0, 26'sd0, 26'sd0};
        tbl[4].ovf = 1'b1;
        // Mixed values: row1 = 1.5*2 + 0.25*(-4) = 2.0, others hand-checked
        tbl[5].z = '{26'sd16384, -26'sd32768, 26'sd0, 26'sd8192};
        for (int i = 0; i < 16; i++) tbl[5].w[i] = 26'sd0;
        tbl[5].w[0]  = 26'sd12288;  tbl[5].w[1]  = 26'sd2048;
        tbl[5].w[5]  = 26'sd8192;   tbl[5].w[7]  = -26'sd8192;
        tbl[5].w[10] = 26'sd8192;   tbl[5].w[15] = -26'sd3;
        tbl[5].y = '{26'sd16384, -26'sd40960, 26'sd0, -26'sd3};
        tbl[5].ovf = 1'b0;

        // Reset state
        #12;
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst.ovf", 64'(bus.out_ovf), 64'd0);
        yv = get_y();
        for (int r = 0; r < 4; r++) chk($sformatf("rst.y%0d", r+1), 64'(yv[r]), 64'd0);
        @(negedge clk_dot);
        rst_dot = 1'b0;
        #1;
        chk("rst_rel.in_ready", 64'(bus.in_ready), 64'd1);

        for (int i = 0; i < 6; i++)
            run_op($sformatf("tbl%0d", i), tbl[i].z, tbl[i].w, tbl[i].y, tbl[i].ovf, (i == 1) ? 5 : 0);

        // Reset in the middle of an operation
        @(negedge clk_dot);
        drive(tbl[1].z, tbl[1].w);
        bus.in_valid = 1'b1;
        @(posedge clk_dot); #1;
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk_dot);
        #2;
        rst_dot = 1'b1;
        #1;
        chk("midrst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst.ovf", 64'(bus.out_ovf), 64'd0);
        chk("midrst.in_ready", 64'(bus.in_ready), 64'd0);
        yv = get_y();
        for (int r = 0; r < 4; r++) chk($sformatf("midrst.y%0d", r+1), 64'(yv[r]), 64'd0);
        @(negedge clk_dot);
        rst_dot = 1'b0;
        #1;
        chk("midrst_rel.in_ready", 64'(bus.in_ready), 64'd1);
        run_op("after_rst", tbl[0].z, tbl[0].w, tbl[0].y, tbl[0].ovf, 0);

        // Randomized operations against the reference model
        for (int k = 0; k < 30; k++) begin
            mode = $urandom_range(0, 2);
            for (int i = 0; i < 4; i++)
                z[i] = (mode == 0) ? DW'($urandom) : DW'(int'($urandom_range(0, 65535)) - 32768);
            for (int i = 0; i < 16; i++)
                w[i] = (mode == 2) ? DW'($urandom) : DW'(int'($urandom_range(0, 65535)) - 32768);
            model(z, w, ey, eovf);
            run_op($sformatf("rnd%0d", k), z, w, ey, eovf, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
